// File: rtl/dice_pkg.sv
// Shared types and dice-total constants for the craps-style dice controller.
package dice_pkg;

  typedef enum logic [2:0] {
    FIRST_WAIT = 3'd0,
    FIRST_ROLL = 3'd1,
    NEXT_WAIT  = 3'd2,
    NEXT_ROLL  = 3'd3,
    WIN        = 3'd4,
    LOSE       = 3'd5
  } state_t;

  localparam int SEVEN   = 7;
  localparam int ELEVEN  = 11;
  localparam int SNAKE   = 2;
  localparam int TREY    = 3;
  localparam int BOXCARS = 12;
  localparam int SUM_MIN = 2;
  localparam int SUM_MAX = 12;

endpackage

// File: rtl/dice_sum_classify.sv
// Combinational verdict on a dice total for either the come-out roll or a point roll.
module dice_sum_classify
  import dice_pkg::*;
#(
  parameter int SUM_W = 4
) (
  input  logic [SUM_W-1:0] i_sum,
  input  logic [SUM_W-1:0] i_point,
  input  logic             i_first,
  output logic             o_win_now,
  output logic             o_lose_now,
  output logic             o_set_point,
  output logic             o_illegal
);

  logic w_is_seven;
  logic w_first_win;
  logic w_first_lose;

  assign o_illegal    = (i_sum < SUM_W'(SUM_MIN)) || (i_sum > SUM_W'(SUM_MAX));
  assign w_is_seven   = (i_sum == SUM_W'(SEVEN));
  assign w_first_win  = w_is_seven || (i_sum == SUM_W'(ELEVEN));
  assign w_first_lose = (i_sum == SUM_W'(SNAKE)) || (i_sum == SUM_W'(TREY)) ||
                        (i_sum == SUM_W'(BOXCARS));

  // A stored point is never 7, so the point match and the seven-out cannot overlap.
  always_comb begin
    o_win_now   = 1'b0;
    o_lose_now  = 1'b0;
    o_set_point = 1'b0;
    if (!o_illegal) begin
      if (i_first) begin
        o_win_now   = w_first_win;
        o_lose_now  = w_first_lose;
        o_set_point = !w_first_win && !w_first_lose;
      end else begin
        o_win_now   = (i_sum == i_point);
        o_lose_now  = w_is_seven && (i_sum != i_point);
      end
    end
  end

endmodule

// File: rtl/dice_controller.sv
// Craps game controller: raises Roll while the button is held, judges Sum on release,
// tracks the point and holds Win/Lose until Reset starts a new game.
module dice_controller
  import dice_pkg::*;
#(
  parameter int SUM_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Rb,
  input  logic [SUM_W-1:0] Sum,
  output logic             Roll,
  output logic             Win,
  output logic             Lose,
  output logic [SUM_W-1:0] Point,
  output logic [CNT_W-1:0] RollCnt,
  output logic             Err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SUM_W-1:0] r_point;
  logic [CNT_W-1:0] r_roll_cnt;
  logic             r_err;
  logic             w_eval;
  logic             w_win_now;
  logic             w_lose_now;
  logic             w_set_point;
  logic             w_illegal;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  dice_sum_classify #(.SUM_W(SUM_W)) u_classify (
    .i_sum       (Sum),
    .i_point     (r_point),
    .i_first     (r_state == FIRST_ROLL),
    .o_win_now   (w_win_now),
    .o_lose_now  (w_lose_now),
    .o_set_point (w_set_point),
    .o_illegal   (w_illegal)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_eval      = 1'b0;
    case (r_state)
      FIRST_WAIT: if (Rb) w_state_nxt = FIRST_ROLL;
      FIRST_ROLL: begin
        if (!Rb) begin
          w_eval = 1'b1;
          if (w_illegal)       w_state_nxt = FIRST_WAIT;
          else if (w_win_now)  w_state_nxt = WIN;
          else if (w_lose_now) w_state_nxt = LOSE;
          else                 w_state_nxt = NEXT_WAIT;
        end
      end
      NEXT_WAIT: if (Rb) w_state_nxt = NEXT_ROLL;
      NEXT_ROLL: begin
        if (!Rb) begin
          w_eval = 1'b1;
          if (w_win_now)       w_state_nxt = WIN;
          else if (w_lose_now) w_state_nxt = LOSE;
          else                 w_state_nxt = NEXT_WAIT;
        end
      end
      WIN:     w_state_nxt = WIN;
      LOSE:    w_state_nxt = LOSE;
      default: w_state_nxt = FIRST_WAIT;
    endcase
  end

  // Reset wins over an evaluating edge, so a roll in flight is simply discarded.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= FIRST_WAIT;
      r_point    <= '0;
      r_roll_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_eval && w_illegal;
      if (w_eval && !w_illegal) r_roll_cnt <= sat_inc(r_roll_cnt);
      if (w_eval && w_set_point) r_point <= Sum;
    end
  end

  assign Roll    = (r_state == FIRST_ROLL) || (r_state == NEXT_ROLL);
  assign Win     = (r_state == WIN);
  assign Lose    = (r_state == LOSE);
  assign Point   = r_point;
  assign RollCnt = r_roll_cnt;
  assign Err     = r_err;

endmodule

// File: tb/tb_dice_controller.sv
// Directed bench for dice_controller: each task plays one game scenario with hand-derived results.
module tb_dice_controller;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Rb = 1'b0;
  logic [3:0] Sum = 4'd0;
  logic       Roll, Win, Lose, Err;
  logic [3:0] Point, RollCnt;

  int total = 0;
  int bad   = 0;

  dice_controller #(.SUM_W(4), .CNT_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .Rb(Rb), .Sum(Sum),
    .Roll(Roll), .Win(Win), .Lose(Lose), .Point(Point),
    .RollCnt(RollCnt), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Press for two cycles, release; returns after the evaluating edge.
  task automatic roll(input logic [3:0] s);
    Rb  = 1'b1;
    Sum = s;
    tick();
    total++;
    if (Roll !== 1'b1) begin bad++; $display("FAIL roll_high: got %b expected 1", Roll); end
    tick();
    Rb = 1'b0;
    tick();
    Sum = 4'd0;
  endtask

  task automatic check_outs(input string name, input logic r, input logic w, input logic l,
                            input logic [3:0] p, input logic [3:0] c, input logic e);
    logic [8:0] act, exp;
    act = {r, w, l, p, c[1:0]};
    exp = {r, w, l, p, c[1:0]};
    act = {Roll, Win, Lose, Point, RollCnt[1:0]};
    total++;
    if (act !== exp || RollCnt !== c || Err !== e) begin
      bad++;
      $display("FAIL %s: got Roll=%b Win=%b Lose=%b Point=%0d Cnt=%0d Err=%b expected Roll=%b Win=%b Lose=%b Point=%0d Cnt=%0d Err=%b",
               name, Roll, Win, Lose, Point, RollCnt, Err, r, w, l, p, c, e);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_outs("reset_state", 0, 0, 0, 4'd0, 4'd0, 0);
  endtask

  task automatic test_first_win();
    do_reset();
    roll(4'd7);
    check_outs("first_7_win", 0, 1, 0, 4'd0, 4'd1, 0);
    do_reset();
    check_outs("reset_after_win", 0, 0, 0, 4'd0, 4'd0, 0);
  endtask

  task automatic test_first_outcomes();
    logic [3:0] sums [4] = '{4'd11, 4'd2, 4'd3, 4'd12};
    logic       wins [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      roll(sums[i]);
      check_outs($sformatf("first_%0d", sums[i]), 0, wins[i], !wins[i], 4'd0, 4'd1, 0);
    end
  endtask

  task automatic test_point_lose();
    do_reset();
    roll(4'd4);
    check_outs("point4_set", 0, 0, 0, 4'd4, 4'd1, 0);
    roll(4'd7);
    check_outs("point4_seven_out", 0, 0, 1, 4'd4, 4'd2, 0);
  endtask

  task automatic test_point_retained();
    do_reset();
    roll(4'd5);
    check_outs("point5_set", 0, 0, 0, 4'd5, 4'd1, 0);
    roll(4'd6);
    check_outs("point5_after6", 0, 0, 0, 4'd5, 4'd2, 0);
    roll(4'd7);
    check_outs("point5_seven_out", 0, 0, 1, 4'd5, 4'd3, 0);
  endtask

  task automatic test_point_win();
    do_reset();
    roll(4'd6);
    check_outs("point6_set", 0, 0, 0, 4'd6, 4'd1, 0);
    roll(4'd8);
    check_outs("point6_after8", 0, 0, 0, 4'd6, 4'd2, 0);
    roll(4'd9);
    check_outs("point6_after9", 0, 0, 0, 4'd6, 4'd3, 0);
    roll(4'd6);
    check_outs("point6_made", 0, 1, 0, 4'd6, 4'd4, 0);
  endtask

  task automatic test_illegal();
    do_reset();
    roll(4'd13);
    check_outs("illegal13_err", 0, 0, 0, 4'd0, 4'd0, 1);
    tick();
    check_outs("illegal13_err_clears", 0, 0, 0, 4'd0, 4'd0, 0);
    roll(4'd7);
    check_outs("illegal13_still_first", 0, 1, 0, 4'd0, 4'd1, 0);
    do_reset();
    roll(4'd4);
    roll(4'd0);
    check_outs("illegal0_next_err", 0, 0, 0, 4'd4, 4'd1, 1);
    roll(4'd7);
    check_outs("illegal0_still_next", 0, 0, 1, 4'd4, 4'd2, 0);
  endtask

  task automatic test_reset_mid_roll();
    do_reset();
    roll(4'd4);
    Rb  = 1'b1;
    Sum = 4'd7;
    tick();
    chk("midroll_roll_high", {3'd0, Roll}, 4'd1);
    Rb    = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_outs("midroll_reset", 0, 0, 0, 4'd0, 4'd0, 0);
    tick();
    check_outs("midroll_no_lose", 0, 0, 0, 4'd0, 4'd0, 0);
  endtask

  task automatic test_hold_in_win();
    do_reset();
    roll(4'd11);
    Rb  = 1'b1;
    Sum = 4'd4;
    for (int i = 0; i < 4; i++) tick();
    check_outs("rb_held_in_win", 0, 1, 0, 4'd0, 4'd1, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_outs("reset_rb_high", 0, 0, 0, 4'd0, 4'd0, 0);
    tick();
    chk("rb_high_starts_roll", {3'd0, Roll}, 4'd1);
    Rb = 1'b0;
    Sum = 4'd3;
    tick();
    check_outs("post_reset_roll_lose", 0, 0, 1, 4'd0, 4'd1, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    roll(4'd4);
    for (int i = 0; i < 16; i++) roll(4'd5);
    check_outs("cnt_saturates", 0, 0, 0, 4'd4, 4'd15, 0);
    roll(4'd4);
    check_outs("cnt_sat_win", 0, 1, 0, 4'd4, 4'd15, 0);
  endtask

  initial begin
    test_reset();
    test_first_win();
    test_first_outcomes();
    test_point_lose();
    test_point_retained();
    test_point_win();
    test_illegal();
    test_reset_mid_roll();
    test_hold_in_win();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
